// File: rtl/unidade_controle_if.sv
// Control bundle between the control FSM and the fetch/datapath side.
// The master side is the control unit; the slave side is memory plus datapath.
interface unidade_controle_if #(
  parameter int LARGURA_INSTR = 8,
  parameter int LARGURA_OP    = 3
);
  logic [LARGURA_INSTR-1:0] instrucao;
  logic                     mem_pronta;
  logic                     le_mem;
  logic                     carrega_ir;
  logic                     incrementa_pc;
  logic                     carrega_pc;
  logic                     sel_operando;
  logic [LARGURA_OP-1:0]    op_ula;
  logic                     escreve_reg;
  logic                     parado;
  logic                     erro_opcode;
  logic [2:0]               estado;

  modport master (
    input  instrucao, mem_pronta,
    output le_mem, carrega_ir, incrementa_pc, carrega_pc, sel_operando,
           op_ula, escreve_reg, parado, erro_opcode, estado
  );

  modport slave (
    output instrucao, mem_pronta,
    input  le_mem, carrega_ir, incrementa_pc, carrega_pc, sel_operando,
           op_ula, escreve_reg, parado, erro_opcode, estado
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the 8-bit processor: fetch, decode, execute, write-back.
// sel_operando steers the downstream 2:1 operand mux (0 = register, 1 = immediate).
module unidade_controle (
  input  logic                clk,
  input  logic                rst,
  unidade_controle_if.master  bus
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCRITA    = 3'd3,
    PARADO     = 3'd4
  } estado_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  estado_t    estado_q, estado_d;
  logic [3:0] opcode_q;
  logic       erro_q, erro_d;
  logic       legal;
  logic       escreve;
  logic [2:0] op_dec;
  logic       imediato;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= BUSCA;
      opcode_q <= OP_NOP;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      erro_q   <= erro_d;
      if (estado_q == BUSCA && bus.mem_pronta)
        opcode_q <= bus.instrucao[7:4];
    end
  end

  // Opcode decode; anything illegal decodes exactly like NOP.
  always_comb begin
    legal    = 1'b1;
    escreve  = 1'b0;
    op_dec   = 3'b000;
    imediato = 1'b0;
    case (opcode_q)
      OP_NOP, OP_JMP, OP_HLT: ;
      OP_ADD:  begin escreve = 1'b1; op_dec = 3'b001; end
      OP_SUB:  begin escreve = 1'b1; op_dec = 3'b010; end
      OP_AND:  begin escreve = 1'b1; op_dec = 3'b011; end
      OP_OR:   begin escreve = 1'b1; op_dec = 3'b100; end
      OP_LDI:  begin escreve = 1'b1; imediato = 1'b1; end
      OP_ADDI: begin escreve = 1'b1; imediato = 1'b1; op_dec = 3'b001; end
      OP_MOV:  escreve = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    estado_d           = BUSCA;
    erro_d             = erro_q;
    bus.le_mem         = 1'b0;
    bus.carrega_ir     = 1'b0;
    bus.incrementa_pc  = 1'b0;
    bus.carrega_pc     = 1'b0;
    bus.sel_operando   = 1'b0;
    bus.op_ula         = 3'b000;
    bus.escreve_reg    = 1'b0;
    bus.parado         = 1'b0;
    case (estado_q)
      BUSCA: begin
        bus.le_mem = 1'b1;
        if (bus.mem_pronta) begin
          bus.carrega_ir    = 1'b1;
          bus.incrementa_pc = 1'b1;
          estado_d          = DECODIFICA;
        end else begin
          estado_d = BUSCA;
        end
      end
      DECODIFICA: begin
        bus.sel_operando = imediato;
        bus.op_ula       = op_dec;
        if (opcode_q == OP_HLT) begin
          estado_d = PARADO;
        end else begin
          estado_d = EXECUTA;
          if (!legal) erro_d = 1'b1;
        end
      end
      EXECUTA: begin
        bus.sel_operando = imediato;
        bus.op_ula       = op_dec;
        bus.carrega_pc   = (opcode_q == OP_JMP);
        estado_d         = escreve ? ESCRITA : BUSCA;
      end
      ESCRITA: begin
        bus.sel_operando = imediato;
        bus.op_ula       = op_dec;
        bus.escreve_reg  = 1'b1;
        estado_d         = BUSCA;
      end
      PARADO: begin
        bus.parado = 1'b1;
        estado_d   = PARADO;
      end
      default: estado_d = BUSCA;
    endcase
  end

  assign bus.erro_opcode = erro_q;
  assign bus.estado      = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle: each instruction is expanded into its
// expected per-cycle output trace from the opcode table and compared cycle by cycle.
module tb_unidade_controle;

  typedef struct packed {
    logic [2:0] estado;
    logic       le_mem;
    logic       carrega_ir;
    logic       incrementa_pc;
    logic       carrega_pc;
    logic       sel_operando;
    logic [2:0] op_ula;
    logic       escreve_reg;
    logic       parado;
    logic       erro_opcode;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic model_erro = 1'b0;

  unidade_controle_if #(.LARGURA_INSTR(8), .LARGURA_OP(3)) bus ();

  unidade_controle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.estado        = bus.estado;
    o.le_mem        = bus.le_mem;
    o.carrega_ir    = bus.carrega_ir;
    o.incrementa_pc = bus.incrementa_pc;
    o.carrega_pc    = bus.carrega_pc;
    o.sel_operando  = bus.sel_operando;
    o.op_ula        = bus.op_ula;
    o.escreve_reg   = bus.escreve_reg;
    o.parado        = bus.parado;
    o.erro_opcode   = bus.erro_opcode;
    return o;
  endfunction

  // Reference opcode table
  function automatic logic [2:0] alu_of(input logic [3:0] opc);
    if (opc == 4'h1 || opc == 4'h6) return 3'b001;
    if (opc == 4'h2) return 3'b010;
    if (opc == 4'h3) return 3'b011;
    if (opc == 4'h4) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic is_legal(input logic [3:0] opc);
    return (opc <= 4'h8) || (opc == 4'hF);
  endfunction

  function automatic logic is_imm(input logic [3:0] opc);
    return (opc == 4'h5) || (opc == 4'h6);
  endfunction

  function automatic logic writes(input logic [3:0] opc);
    return (opc >= 4'h1) && (opc <= 4'h7);
  endfunction

  function automatic obs_t idle();
    obs_t e = '0;
    e.le_mem      = 1'b1;
    e.erro_opcode = model_erro;
    return e;
  endfunction

  // Inputs are already driven (posedge+1); compare on the falling edge, then advance.
  task automatic cycle(input obs_t exp, input string name);
    obs_t act;
    @(negedge clk);
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] instr, input int waits, input string tag);
    obs_t e;
    logic [3:0] opc;
    opc = instr[7:4];
    for (int i = 0; i < waits; i++) begin
      bus.mem_pronta = 1'b0;
      bus.instrucao  = 8'($urandom);
      cycle(idle(), {tag, "_wait"});
    end
    bus.mem_pronta = 1'b1;
    bus.instrucao  = instr;
    e = idle();
    e.carrega_ir    = 1'b1;
    e.incrementa_pc = 1'b1;
    cycle(e, {tag, "_fetch"});
    bus.mem_pronta = 1'($urandom);
    bus.instrucao  = 8'($urandom);

    e = '0;
    e.estado       = 3'd1;
    e.sel_operando = is_imm(opc);
    e.op_ula       = alu_of(opc);
    e.erro_opcode  = model_erro;
    cycle(e, {tag, "_decode"});
    if (opc == 4'hF) return;
    if (!is_legal(opc)) model_erro = 1'b1;

    e.estado      = 3'd2;
    e.carrega_pc  = (opc == 4'h8);
    e.erro_opcode = model_erro;
    cycle(e, {tag, "_execute"});

    if (writes(opc)) begin
      e.estado      = 3'd3;
      e.carrega_pc  = 1'b0;
      e.escreve_reg = 1'b1;
      cycle(e, {tag, "_write"});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_pronta = 1'b0;
    bus.instrucao  = 8'h00;
    model_erro = 1'b0;
    cycle(idle(), "reset_held");
    rst = 1'b0;
    cycle(idle(), "reset_released");
  endtask

  task automatic test_add();
    run_instr(8'h13, 0, "add");
  endtask

  task automatic test_ldi();
    run_instr(8'h57, 0, "ldi");
  endtask

  task automatic test_wait();
    run_instr(8'h47, 5, "wait_or");
  endtask

  task automatic test_jmp_hlt();
    obs_t e;
    run_instr(8'h84, 0, "jmp");
    run_instr(8'hF0, 0, "hlt");
    for (int i = 0; i < 4; i++) begin
      bus.mem_pronta = 1'b1;
      bus.instrucao  = 8'h13;
      e = '0;
      e.estado      = 3'd4;
      e.parado      = 1'b1;
      e.erro_opcode = model_erro;
      cycle(e, "halted");
    end
  endtask

  task automatic test_illegal();
    run_instr(8'hA0, 0, "illegal");
    run_instr(8'h00, 1, "nop_after_illegal");
    run_instr(8'h21, 0, "sub_sticky");
  endtask

  task automatic test_random(input int n, input string tag);
    logic [7:0] instr;
    for (int i = 0; i < n; i++) begin
      instr = {4'($urandom_range(0, 14)), 4'($urandom)};
      run_instr(instr, int'($urandom_range(0, 3)), tag);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    obs_t act;
    bus.mem_pronta = 1'b1;
    bus.instrucao  = 8'h13;
    e = idle();
    e.carrega_ir    = 1'b1;
    e.incrementa_pc = 1'b1;
    cycle(e, "mid_fetch");
    e = '0;
    e.estado      = 3'd1;
    e.op_ula      = 3'b001;
    e.erro_opcode = model_erro;
    bus.mem_pronta = 1'b0;
    cycle(e, "mid_decode");
    // Now in EXECUTA: hit reset away from any clock edge.
    @(negedge clk);
    rst = 1'b1;
    model_erro = 1'b0;
    #1;
    act = sample();
    checks++;
    if (act !== idle()) begin
      failures++;
      $display("FAIL reset_mid_async: got %h required %h", act, idle());
    end
    @(posedge clk);
    #1;
    cycle(idle(), "reset_mid_held");
    rst = 1'b0;
    cycle(idle(), "reset_mid_released");
    run_instr(8'h61, 0, "addi_after_reset");
  endtask

  initial begin
    bus.mem_pronta = 1'b0;
    bus.instrucao  = 8'h00;
    #2;
    test_reset();
    test_add();
    test_ldi();
    test_wait();
    test_jmp_hlt();
    test_reset();
    test_illegal();
    test_random(40, "rand_a");
    test_reset_mid();
    test_random(20, "rand_b");
    run_instr(8'hF3, 2, "final_hlt");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
